// File: rtl/ifetch_buffer_if.sv
// ifetch_buffer_if -- instruction-memory bus between the fetch buffer and
// the instruction memory.
//
// Signals:
//   imem_req    fetch side -> memory : request valid this cycle
//   imem_addr   fetch side -> memory : word-aligned fetch address
//   imem_ack    memory -> fetch side : request accepted this cycle
//   imem_rvalid memory -> fetch side : in-order response word valid
//   imem_rdata  memory -> fetch side : response instruction word
//
// Handshake: a request transfers on every rising edge where imem_req and
// imem_ack are both 1 (imem_ack plays the role of ready). imem_req may
// drop without a transfer. Responses have no back-pressure: a cycle with
// imem_rvalid=1 delivers exactly one word, in the order the requests were
// accepted.
//
// Modports: master = fetch buffer, slave = instruction memory.
interface ifetch_buffer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_buffer.sv
// ifetch_buffer -- prefetching instruction queue between instruction memory
// and the decode stage. Keeps up to DEPTH instructions either queued or in
// flight, flushes on redirect and drops responses to requests issued before
// the redirect.
//
// Parameters:
//   DEPTH     queue entries, power of two, 2..16
//   RESET_PC  first fetch address after reset
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   StallF       decode not accepting; head entry held
//   redirect     branch / PC-write redirect
//   redirect_pc  new fetch address, valid with redirect
//   imem         instruction-memory bus (ifetch_buffer_if.master)
//   InstrF       head instruction (0 when nothing valid)
//   PCF          address of head instruction (fetch pointer when empty)
//   InstrValidF  head entry valid
//
// Build option: define IFETCH_BYPASS_EN to forward a response straight to
// decode when the queue is empty and no discard is pending.
module ifetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   StallF,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  ifetch_buffer_if.master        imem,
  output logic [31:0]            InstrF,
  output logic [31:0]            PCF,
  output logic                   InstrValidF
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fpc;
  logic [CW-1:0] occ;
  logic [CW-1:0] outst;
  logic [CW-1:0] disc;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic [CW:0]   inflight;
  logic          accept;
  logic          dropping;
  logic          rsp_live;
  logic [CW-1:0] live_cnt;
  logic [31:0]   rsp_pc;
  logic          q_empty;
  logic          bypass;
  logic          push;
  logic          pop;

  // Queued plus in-flight words never exceed DEPTH, so a push can never
  // land on a full queue.
  assign inflight      = {1'b0, occ} + {1'b0, outst};
  assign imem.imem_req  = reset & (inflight < (CW+1)'(DEPTH));
  assign imem.imem_addr = fpc;

  assign accept   = imem.imem_req & imem.imem_ack;
  assign dropping = (disc != '0);
  assign rsp_live = imem.imem_rvalid & ~dropping;
  assign q_empty  = (occ == '0);

  // The non-discarded in-flight requests are the most recent ones and are
  // contiguous up to fpc-4, so the oldest live response belongs to
  // fpc - 4*(outstanding - discard).
  assign live_cnt = outst - disc;
  assign rsp_pc   = fpc - (32'(live_cnt) << 2);

`ifdef IFETCH_BYPASS_EN
  assign bypass = reset & q_empty & rsp_live;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = ~q_empty & ~StallF;
  // A bypassed word that decode takes this cycle is not queued.
  assign push = rsp_live & ~(bypass & ~StallF);

  always_comb begin
    InstrValidF = 1'b0;
    InstrF      = 32'h0000_0000;
    PCF         = fpc;
    if (!q_empty) begin
      InstrValidF = 1'b1;
      InstrF      = q_instr[head];
      PCF         = q_pc[head];
    end else if (bypass) begin
      InstrValidF = 1'b1;
      InstrF      = imem.imem_rdata;
      PCF         = rsp_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc   <= RESET_PC;
      occ   <= '0;
      outst <= '0;
      disc  <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      outst <= outst + CW'(accept) - CW'(imem.imem_rvalid);
      if (redirect) begin
        // Everything still in flight after this edge, including a request
        // accepted right now, belongs to the old path.
        fpc  <= {redirect_pc[31:2], 2'b00};
        occ  <= '0;
        head <= '0;
        tail <= '0;
        disc <= outst + CW'(accept) - CW'(imem.imem_rvalid);
      end else begin
        if (accept) fpc <= fpc + 32'd4;
        if (dropping && imem.imem_rvalid) disc <= disc - CW'(1);
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage needs no reset; occupancy alone marks entries valid.
  always_ff @(posedge clk) begin
    if (push && !redirect) begin
      q_instr[tail] <= imem.imem_rdata;
      q_pc[tail]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer -- self-checking bench for ifetch_buffer.
// Reference model: after reset or a redirect to X, decode must receive the
// words at X, X+4, X+8, ... in order, each equal to the memory contents at
// that address. The expected stream lives in exp_q; a monitor compares every
// instruction decode consumes. A memory model returns in-order responses
// with randomized acceptance and response rates.
module tb_ifetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StallF = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        InstrValidF;

  ifetch_buffer_if imem_if ();

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_if),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .InstrValidF (InstrValidF)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_deliv  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] gen_pc;
  logic [31:0] pend_q[$];
  int          ack_pct  = 0;
  int          rv_pct   = 0;
  bit          mem_hold = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A0_1005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({gen_pc, mem_word(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = pc;
    refill();
  endtask

  // ---------------- memory model ----------------
  initial begin
    imem_if.imem_ack    = 1'b0;
    imem_if.imem_rvalid = 1'b0;
    imem_if.imem_rdata  = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        imem_if.imem_ack    = 1'b0;
        imem_if.imem_rvalid = 1'b0;
        imem_if.imem_rdata  = 32'h0;
      end else begin
        imem_if.imem_ack = ($urandom_range(0, 99) < ack_pct);
        if (!mem_hold && pend_q.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
          imem_if.imem_rvalid = 1'b1;
          imem_if.imem_rdata  = mem_word(pend_q[0]);
        end else begin
          imem_if.imem_rvalid = 1'b0;
          imem_if.imem_rdata  = $urandom;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (imem_if.imem_rvalid && pend_q.size() > 0) void'(pend_q.pop_front());
        if (imem_if.imem_req && imem_if.imem_ack) pend_q.push_back(imem_if.imem_addr);
        if (InstrValidF && !StallF && !redirect) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL deliver_unexpected: got pc %h with no expected entry", PCF);
          end else begin
            e = exp_q.pop_front();
            check32("deliver_pc", PCF, e[63:32]);
            check32("deliver_instr", InstrF, e[31:0]);
            n_deliv++;
            refill();
          end
        end
        if (!InstrValidF) check32("empty_instr_zero", InstrF, 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    redirect = 1'b0;
    mem_hold = 1'b1;
    ack_pct  = 0;
    rv_pct   = 0;
    pend_q.delete();
    repeat (2) tick();
    check32("rst_req", imem_if.imem_req, 1'b0);
    check32("rst_valid", InstrValidF, 1'b0);
    check32("rst_instr", InstrF, 32'h0);
    check32("rst_pcf", PCF, RESET_PC);
    reset = 1'b1;
    restart_stream(RESET_PC);
  endtask

  task automatic wait_valid(input int max, input string name);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (InstrValidF) break;
    end
    check32(name, InstrValidF, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  acc;
    bit  found;
    int  d0;

    // Fill and stream: one instruction per cycle with no bubbles.
    do_reset();
    StallF = 1'b0; mem_hold = 1'b0; ack_pct = 100; rv_pct = 100;
    @(negedge clk);
    check32("first_req", imem_if.imem_req, 1'b1);
    check32("first_addr", imem_if.imem_addr, RESET_PC);
    wait_valid(20, "fill_valid");
    check32("pc_seq0", PCF, RESET_PC);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check32("no_bubble", InstrValidF, 1'b1);
      check32("pc_seq", PCF, RESET_PC + 32'(i * 4));
    end

    // Decode stalled: requests stop at DEPTH, head frozen.
    tick();
    do_reset();
    StallF = 1'b1; mem_hold = 1'b0; ack_pct = 100; rv_pct = 100;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_if.imem_req && imem_if.imem_ack) acc++;
    end
    check32("stall_accepts", 32'(acc), 32'(DEPTH));
    check32("stall_req_low", imem_if.imem_req, 1'b0);
    check32("stall_valid", InstrValidF, 1'b1);
    check32("stall_pcf", PCF, RESET_PC);
    check32("stall_instr", InstrF, mem_word(RESET_PC));
    tick();
    StallF = 1'b0;
    repeat (10) tick();

    // Redirect with two requests in flight.
    do_reset();
    StallF = 1'b0; mem_hold = 1'b1; ack_pct = 100; rv_pct = 100;
    tick(); tick();
    ack_pct = 0;
    tick();
    check32("two_outstanding", 32'(pend_q.size()), 32'd2);
    redirect = 1'b1; redirect_pc = 32'h100;
    restart_stream(32'h100);
    tick();
    redirect = 1'b0; mem_hold = 1'b0; ack_pct = 100;
    wait_valid(20, "redir_valid");
    check32("redir_pc", PCF, 32'h100);
    check32("redir_instr", InstrF, mem_word(32'h100));

    // Redirect in a cycle with a response arriving and a pop happening.
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (InstrValidF && imem_if.imem_rvalid && imem_if.imem_req && imem_if.imem_ack) begin
        found = 1'b1;
        break;
      end
    end
    check32("redir2_setup", found, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h200;
    restart_stream(32'h200);
    tick();
    redirect = 1'b0;
    check32("redir2_flushed", InstrValidF, 1'b0);
    wait_valid(20, "redir2_valid");
    check32("redir2_pc", PCF, 32'h200);

    // Empty-queue response timing (bypass vs queued).
    tick();
    do_reset();
    StallF = 1'b0; mem_hold = 1'b1; ack_pct = 100; rv_pct = 100;
    tick();
    ack_pct = 0;
    tick(); tick(); tick();
    check32("byp_one_out", 32'(pend_q.size()), 32'd1);
    check32("byp_empty", InstrValidF, 1'b0);
    mem_hold = 1'b0;
    tick();
    check32("byp_rvalid", imem_if.imem_rvalid, 1'b1);
`ifdef IFETCH_BYPASS_EN
    check32("byp_valid_now", InstrValidF, 1'b1);
    check32("byp_instr_now", InstrF, 32'hE3A0_1005);
    check32("byp_pc_now", PCF, 32'h0);
    tick();
    check32("byp_consumed", InstrValidF, 1'b0);
`else
    check32("nobyp_not_yet", InstrValidF, 1'b0);
    tick();
    check32("nobyp_valid", InstrValidF, 1'b1);
    check32("nobyp_instr", InstrF, 32'hE3A0_1005);
    check32("nobyp_pc", PCF, 32'h0);
`endif

    // Reset mid-burst with three entries queued.
    tick();
    do_reset();
    StallF = 1'b1; mem_hold = 1'b0; ack_pct = 100; rv_pct = 100;
    repeat (5) tick();
    check32("pre_reset_valid", InstrValidF, 1'b1);
    check32("pre_reset_pcf", PCF, RESET_PC);
    reset = 1'b0;
    pend_q.delete();
    #1;
    check32("midrst_req", imem_if.imem_req, 1'b0);
    check32("midrst_valid", InstrValidF, 1'b0);
    check32("midrst_instr", InstrF, 32'h0);
    check32("midrst_pcf", PCF, RESET_PC);
    tick(); tick();
    StallF = 1'b0;
    reset = 1'b1;
    restart_stream(RESET_PC);
    @(negedge clk);
    check32("restart_req", imem_if.imem_req, 1'b1);
    check32("restart_addr", imem_if.imem_addr, RESET_PC);
    wait_valid(20, "restart_valid");
    check32("restart_pc", PCF, RESET_PC);

    // Randomized traffic: stalls, redirects, variable memory rates.
    d0 = n_deliv;
    for (int seg = 0; seg < 10; seg++) begin
      ack_pct = $urandom_range(30, 100);
      rv_pct  = $urandom_range(30, 100);
      for (int c = 0; c < 150; c++) begin
        tick();
        StallF = ($urandom_range(0, 99) < 30);
        if ($urandom_range(0, 99) < 3) begin
          redirect    = 1'b1;
          redirect_pc = 32'($urandom_range(0, 4095)) << 2;
          restart_stream(redirect_pc);
        end else begin
          redirect = 1'b0;
        end
      end
    end
    tick();
    redirect = 1'b0;
    StallF   = 1'b0;
    repeat (20) tick();
    check32("random_deliveries", (n_deliv - d0) > 100, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
